// File: rtl/regbank_wr_arb.sv
// regbank_wr_arb: round-robin arbiter sharing the single write port
// (write/dr/wrData) of the register bank among NREQ requesters, with an
// optional lock that lets one requester hold the port for up to MAXLOCK
// consecutive beats. Write outputs are registered and feed the bank directly.
//
// Handshake: requester i offers a beat by raising req_valid[i] with req_dr /
// req_data / req_lock stable. The beat is accepted in the cycle where
// req_valid[i] & req_ready[i] is 1; req_ready is combinational, one-hot or
// zero, and never depends on req_lock. The accepted beat appears on the bank
// port one cycle later (write=1 with dr/wrData).
module regbank_wr_arb #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int AW      = 2,
  parameter int MAXLOCK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arb_en,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*AW-1:0]   req_dr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 write,
  output logic [AW-1:0]        dr,
  output logic [DW-1:0]        wrData,
  output logic [2:0]           grant_id,
  output logic                 locked,
  output logic [15:0]          wr_count,
  output logic                 dbg_state
);

  // Pointer width; a single requester still gets a 1-bit index.
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW1 = PW + 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [3:0]    LOCK_MAX = 4'(MAXLOCK);
  // With MAXLOCK=1 a lock could never extend past its first beat.
  localparam bit            LOCK_OK  = (MAXLOCK > 1);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   cur_id;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   sel;
  logic [PW:0]     cand;
  logic [3:0]      lock_cnt;
  logic            found;
  logic            accept;
  logic [AW-1:0]   sel_dr;
  logic [DW-1:0]   sel_data;

  // dbg_state is 1 while a lock burst owns the port.
  assign dbg_state = state;
  assign accept    = |req_ready;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + PW1'(k);
      if (cand >= PW1'(NREQ)) begin
        cand = cand - PW1'(NREQ);
      end
      if (!found && req_valid[cand[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  // FSM outputs: ready vector and the selected requester for this cycle.
  always_comb begin
    req_ready = '0;
    sel       = win_idx;
    if (state == ST_LOCK) begin
      sel               = cur_id;
      req_ready[cur_id] = arb_en & req_valid[cur_id];
    end else if (arb_en && found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Pick the selected requester's destination register and data.
  always_comb begin
    sel_dr   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == PW'(i)) begin
        sel_dr   = req_dr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Next state: enter LOCK on a locked grant, leave on unlock, limit or bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB: begin
        if (accept && req_lock[sel] && LOCK_OK) begin
          state_nxt = ST_LOCK;
        end
      end
      ST_LOCK: begin
        // With arb_en low everything freezes so the burst can resume.
        if (arb_en) begin
          if (!req_valid[cur_id]) begin
            state_nxt = ST_ARB;
          end else if (!req_lock[cur_id] || (lock_cnt + 4'd1 == LOCK_MAX)) begin
            state_nxt = ST_ARB;
          end
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // Round-robin pointer (advanced only by ARB grants) and lock beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      lock_cnt <= '0;
    end else if (accept) begin
      if (state == ST_ARB) begin
        rr_ptr   <= (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);
        lock_cnt <= (state_nxt == ST_LOCK) ? 4'd1 : 4'd0;
      end else begin
        lock_cnt <= (state_nxt == ST_LOCK) ? lock_cnt + 4'd1 : 4'd0;
      end
    end else if (state == ST_LOCK && state_nxt == ST_ARB) begin
      lock_cnt <= '0;
    end
  end

  // Registered bank write port, owner id, lock flag and beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write    <= 1'b0;
      dr       <= '0;
      wrData   <= '0;
      grant_id <= '0;
      cur_id   <= '0;
      locked   <= 1'b0;
      wr_count <= '0;
    end else begin
      write  <= accept;
      locked <= (state_nxt == ST_LOCK);
      if (accept) begin
        dr       <= sel_dr;
        wrData   <= sel_data;
        grant_id <= 3'(sel);
        cur_id   <= sel;
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  // Structural invariants of the grant logic.
  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));
  a_lock_bound : assert property (@(posedge clk) disable iff (!rst_n)
    lock_cnt <= LOCK_MAX);

endmodule

// File: tb/tb_regbank_wr_arb.sv
// Testbench for regbank_wr_arb: directed scenarios plus randomized traffic,
// checked against a behavioural model of the arbitration rules.
module tb_regbank_wr_arb;

  localparam int NREQ    = 4;
  localparam int DW      = 32;
  localparam int AW      = 2;
  localparam int MAXLOCK = 4;
  // Expected write entry: {dr, data, grant id, wr_count after the beat}
  localparam int EW      = AW + DW + 3 + 16;
  localparam int ID_LO   = 16;
  localparam int D_LO    = 19;
  localparam int DR_LO   = 19 + DW;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                arb_en;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_lock;
  logic [NREQ*AW-1:0]  req_dr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                write;
  logic [AW-1:0]       dr;
  logic [DW-1:0]       wrData;
  logic [2:0]          grant_id;
  logic                locked;
  logic [15:0]         wr_count;
  logic                dbg_state;

  regbank_wr_arb #(.NREQ(NREQ), .DW(DW), .AW(AW), .MAXLOCK(MAXLOCK)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
    .req_valid(req_valid), .req_lock(req_lock), .req_dr(req_dr), .req_data(req_data),
    .req_ready(req_ready), .write(write), .dr(dr), .wrData(wrData),
    .grant_id(grant_id), .locked(locked), .wr_count(wr_count), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  int  glog[$];
  int  exp_g[$];
  int  rem[NREQ];
  bit  lk[NREQ];
  bit  rand_flip;
  bit  chk_en;
  logic [NREQ-1:0] acc;

  // reference model state
  int m_ptr, m_holder, m_beats, m_count;
  bit m_lock, m_wr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  initial begin : model_proc
    logic [NREQ-1:0] er;
    int w;
    forever begin
      @(negedge clk);
      er = '0;
      w  = -1;
      if (arb_en) begin
        if (m_lock) begin
          if (req_valid[m_holder]) w = m_holder;
        end else begin
          for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
          end
        end
      end
      if (w >= 0) er[w] = 1'b1;
      if (chk_en) begin
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("locked", 64'(locked), 64'(m_lock));
        chk("dbg_state", 64'(dbg_state), 64'(m_lock));
        chk("write", 64'(write), 64'(m_wr));
        chk("wr_count", 64'(wr_count), 64'(m_count[15:0]));
      end
      if (!rst_n) begin
        m_ptr = 0; m_lock = 0; m_holder = 0; m_beats = 0; m_count = 0; m_wr = 0;
      end else begin
        m_wr = (w >= 0);
        if (w >= 0) begin
          m_count = (m_count + 1) % 65536;
          exp_q.push_back({req_dr[w*AW +: AW], req_data[w*DW +: DW], 3'(w), 16'(m_count)});
          if (!m_lock) begin
            m_ptr = (w + 1) % NREQ;
            if (req_lock[w] && MAXLOCK > 1) begin
              m_lock = 1; m_holder = w; m_beats = 1;
            end
          end else begin
            m_beats++;
            if (!req_lock[w] || m_beats >= MAXLOCK) m_lock = 0;
          end
        end else if (arb_en && m_lock) begin
          m_lock = 0;   // a bubble from the holder ends the burst
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor_proc
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (chk_en && write === 1'b1) begin
        glog.push_back(int'(grant_id));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write at %0t: got write=1 expected no write", $time);
        end else begin
          e = exp_q.pop_front();
          chk("wr_dr", 64'(dr), 64'(e[DR_LO +: AW]));
          chk("wr_data", 64'(wrData), 64'(e[D_LO +: DW]));
          chk("wr_grant_id", 64'(grant_id), 64'(e[ID_LO +: 3]));
          chk("wr_count_at_write", 64'(wr_count), 64'(e[15:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic new_beat(input int i);
    req_dr[i*AW +: AW]   = AW'($urandom_range(0, (1 << AW) - 1));
    req_data[i*DW +: DW] = $urandom();
    req_lock[i]          = lk[i] && !(rand_flip && $urandom_range(0, 7) == 0);
  endtask

  task automatic set_req(input int i, input int n, input bit l);
    rem[i] = n;
    lk[i]  = l;
    new_beat(i);
    req_valid[i] = (n > 0);
  endtask

  task automatic cycle();
    @(negedge clk);
    acc = req_valid & req_ready;
    if (!rst_n) acc = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        rem[i]--;
        if (rem[i] > 0) new_beat(i);
        req_valid[i] = (rem[i] > 0);
      end
    end
  endtask

  function automatic bit busy();
    bit b = 0;
    for (int i = 0; i < NREQ; i++) if (rem[i] > 0) b = 1;
    return b;
  endfunction

  task automatic drain(input int maxc, input string name);
    int c = 0;
    while (busy() && c < maxc) begin
      cycle();
      c++;
    end
    if (busy()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: requests still pending after %0d cycles, required none", name, maxc);
      for (int i = 0; i < NREQ; i++) rem[i] = 0;
      req_valid = '0;
    end
    cycle();
    cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    glog.delete();
  endtask

  task automatic check_log(input string name);
    for (int k = 0; k < exp_g.size(); k++) begin
      if (k >= glog.size()) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_grant%0d: got no grant, expected requester %0d", name, k, exp_g[k]);
      end else begin
        chk($sformatf("%s_grant%0d", name, k), 64'(glog[k]), 64'(exp_g[k]));
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; arb_en = 1'b1;
    req_valid = '0; req_lock = '0; req_dr = '0; req_data = '0;
    rand_flip = 0; chk_en = 0; acc = '0;
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; lk[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_dr", 64'(dr), 64'd0);
    chk("rst_wrData", 64'(wrData), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
    rst_n = 1'b1;

    // single write to dr 2
    set_req(0, 1, 0);
    req_dr[1:0]    = 2'd2;
    req_data[31:0] = 32'hDEADBEEF;
    cycle();
    chk("t1_write", 64'(write), 64'd1);
    chk("t1_dr", 64'(dr), 64'd2);
    chk("t1_wrData", 64'(wrData), 64'hDEADBEEF);
    chk("t1_grant_id", 64'(grant_id), 64'd0);
    chk("t1_wr_count", 64'(wr_count), 64'd1);
    cycle();

    // all four requesting, no lock: plain rotation
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 2, 0);
    drain(40, "t2");
    exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_log("t2");
    chk("t2_wr_count", 64'(wr_count), 64'd8);

    // requester 2 locked for 6 beats against 0,1,3: capped at MAXLOCK
    do_reset();
    set_req(1, 1, 0);
    cycle();
    set_req(0, 3, 0);
    set_req(1, 3, 0);
    set_req(2, 6, 1);
    set_req(3, 3, 0);
    drain(60, "t3");
    exp_g = '{1, 2, 2, 2, 2, 3, 0, 1};
    check_log("t3");

    // requester 1 locked, then a bubble releases the lock
    do_reset();
    set_req(1, 2, 1);
    cycle();
    set_req(0, 1, 0);
    set_req(3, 1, 0);
    drain(30, "t4");
    exp_g = '{1, 1, 3, 0};
    check_log("t4");

    // freeze for 3 cycles in the middle of a lock burst
    do_reset();
    set_req(2, 6, 1);
    cycle();
    set_req(0, 2, 0);
    cycle();
    arb_en = 1'b0;
    repeat (3) begin
      cycle();
      chk("t5_freeze_write", 64'(write), 64'd0);
      chk("t5_freeze_locked", 64'(locked), 64'd1);
    end
    arb_en = 1'b1;
    drain(40, "t5");
    exp_g = '{2, 2, 2, 2, 2, 2, 0};
    exp_g = exp_g[2:6];
    check_log("t5");

    // reset in the middle of a burst
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 3, 1);
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    glog.delete();
    chk("t6_write", 64'(write), 64'd0);
    chk("t6_locked", 64'(locked), 64'd0);
    chk("t6_wr_count", 64'(wr_count), 64'd0);
    drain(80, "t6");
    exp_g = '{0};
    check_log("t6");

    // randomized traffic
    rand_flip = 1;
    do_reset();
    repeat (800) begin
      cycle();
      arb_en = ($urandom_range(0, 9) != 0);
      rst_n  = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 2) == 0)
          set_req(i, $urandom_range(1, 6), bit'($urandom_range(0, 1)));
      end
    end
    arb_en = 1'b1;
    rst_n  = 1'b1;
    drain(300, "rand");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
